// File: rtl/dump_sequencer_if.sv
// UART byte-launch channel between the dump sequencer and a byte transmitter.
// Handshake: tx_start_o pulses for one cycle only while tx_done_i is 1; tx_data_o stays stable until the next launch.
interface dump_sequencer_if #(
    parameter int N_BITS = 8
);
    logic              tx_start_o;
    logic [N_BITS-1:0] tx_data_o;
    logic              tx_done_i;

    modport master (
        output tx_start_o,
        output tx_data_o,
        input  tx_done_i
    );

    modport slave (
        input  tx_start_o,
        input  tx_data_o,
        output tx_done_i
    );
endinterface

// File: rtl/dump_sequencer.sv
// Streams the register file, data memory, PC and cycle counter out over a UART,
// one byte in flight at a time, each word least-significant byte first.
module dump_sequencer #(
    parameter int NB_DATA       = 32,
    parameter int NB_REG        = 5,
    parameter int NB_ADDR       = 7,
    parameter int N_REGISTER    = 32,
    parameter int N_MEMORY_DATA = 127,
    parameter int N_BITS        = 8
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    dump_sequencer_if.master   uart,
    output logic [NB_REG-1:0]  addr_reg_o,
    input  logic [NB_DATA-1:0] data_reg_i,
    output logic [NB_ADDR-1:0] addr_mem_o,
    input  logic [NB_DATA-1:0] data_mem_i,
    input  logic [6:0]         pc_i,
    input  logic [NB_DATA-1:0] cycles_i,
    output logic               sel_debug_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, LAUNCH, WAIT_BUSY, WAIT_IDLE, ADVANCE, DONE
    } state_t;

    typedef enum logic [1:0] {
        SEC_REG, SEC_MEM, SEC_PC, SEC_CYC
    } section_t;

    state_t             state_q, state_d;
    section_t           section_q, section_d;
    logic [1:0]         index_q, index_d;
    logic [NB_DATA-1:0] buffer_q, buffer_d;
    logic [NB_REG-1:0]  addr_reg_q, addr_reg_d;
    logic [NB_ADDR-1:0] addr_mem_q, addr_mem_d;
    logic [N_BITS-1:0]  tx_data_q, tx_data_d;
    logic [N_BITS-1:0]  cur_byte;
    logic               tx_start;
    logic               last_byte;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            section_q  <= SEC_REG;
            index_q    <= 2'd0;
            buffer_q   <= '0;
            addr_reg_q <= '0;
            addr_mem_q <= '0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            section_q  <= section_d;
            index_q    <= index_d;
            buffer_q   <= buffer_d;
            addr_reg_q <= addr_reg_d;
            addr_mem_q <= addr_mem_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_comb begin
        cur_byte = buffer_q[0 +: N_BITS];
        case (index_q)
            2'd1:    cur_byte = buffer_q[N_BITS +: N_BITS];
            2'd2:    cur_byte = buffer_q[2*N_BITS +: N_BITS];
            2'd3:    cur_byte = buffer_q[3*N_BITS +: N_BITS];
            default: cur_byte = buffer_q[0 +: N_BITS];
        endcase
    end

    // The PC section carries a single byte; every other section carries a full word.
    assign last_byte = (section_q == SEC_PC) || (index_q == 2'd3);

    always_comb begin
        state_d    = state_q;
        section_d  = section_q;
        index_d    = index_q;
        buffer_d   = buffer_q;
        addr_reg_d = addr_reg_q;
        addr_mem_d = addr_mem_q;
        tx_data_d  = tx_data_q;
        tx_start   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = FETCH;
                    section_d  = SEC_REG;
                    index_d    = 2'd0;
                    addr_reg_d = '0;
                    addr_mem_d = '0;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                case (section_q)
                    SEC_REG: buffer_d = data_reg_i;
                    SEC_MEM: buffer_d = data_mem_i;
                    SEC_PC:  buffer_d = NB_DATA'(pc_i);
                    default: buffer_d = cycles_i;
                endcase
                state_d = LAUNCH;
            end
            LAUNCH: begin
                if (uart.tx_done_i) begin
                    tx_start  = 1'b1;
                    tx_data_d = cur_byte;
                    state_d   = WAIT_BUSY;
                end
            end
            WAIT_BUSY: if (!uart.tx_done_i) state_d = WAIT_IDLE;
            WAIT_IDLE: if (uart.tx_done_i) state_d = ADVANCE;
            ADVANCE: begin
                if (!last_byte) begin
                    index_d = index_q + 2'd1;
                    state_d = LAUNCH;
                end else begin
                    index_d = 2'd0;
                    case (section_q)
                        SEC_REG: begin
                            state_d = FETCH;
                            if (addr_reg_q == NB_REG'(N_REGISTER - 1)) begin
                                addr_reg_d = '0;
                                section_d  = SEC_MEM;
                            end else begin
                                addr_reg_d = addr_reg_q + 1'b1;
                            end
                        end
                        SEC_MEM: begin
                            if (addr_mem_q == NB_ADDR'(N_MEMORY_DATA - 1)) begin
                                addr_mem_d = '0;
                                section_d  = SEC_PC;
                                state_d    = LATCH;
                            end else begin
                                addr_mem_d = addr_mem_q + 1'b1;
                                state_d    = FETCH;
                            end
                        end
                        SEC_PC: begin
                            section_d = SEC_CYC;
                            state_d   = LATCH;
                        end
                        default: state_d = DONE;
                    endcase
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The launched byte is shown combinationally in the launch cycle and held in tx_data_q afterwards.
    assign uart.tx_start_o = tx_start;
    assign uart.tx_data_o  = tx_start ? cur_byte : tx_data_q;
    assign addr_reg_o      = addr_reg_q;
    assign addr_mem_o      = addr_mem_q;
    assign busy_o          = (state_q != IDLE);
    assign sel_debug_o     = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign state_o         = 3'(state_q);

endmodule

// File: doc/dump_sequencer.md
DUMP_SEQUENCER -- requirements
Module: dump_sequencer

Interface
REQ-001 Parameters SHALL be: NB_DATA 32, 32-bit word width; NB_REG 5, register address width; NB_ADDR 7, memory address width; N_REGISTER 32, registers dumped; N_MEMORY_DATA 127, memory words dumped; N_BITS 8, UART byte width.
REQ-002 Ports SHALL be (name direction width meaning):
- clock_i  in  1  single clock; all logic on posedge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  request one full dump; sampled in IDLE only.
- tx_done_i  in  1  UART transmitter idle level; 1 = idle or byte finished.
- tx_start_o  out  1  one-cycle pulse launching a byte.
- tx_data_o  out  8  byte for the UART; stable from the tx_start_o cycle until the next launch.
- addr_reg_o  out  NB_REG  register-file debug read address.
- data_reg_i  in  NB_DATA  register-file read data, valid 1 cycle after address.
- addr_mem_o  out  NB_ADDR  data-memory debug read address.
- data_mem_i  in  NB_DATA  data-memory read data, valid 1 cycle after address.
- pc_i  in  7  current PC.
- cycles_i  in  NB_DATA  pipeline cycle counter.
- sel_debug_o  out  1  steers register and memory read ports to this block; 1 whenever not IDLE.
- busy_o  out  1  1 whenever not IDLE.
- done_o  out  1  one-cycle pulse at dump completion.

Function
REQ-003 FSM states SHALL be IDLE, FETCH, LATCH, LAUNCH, WAIT_BUSY, WAIT_IDLE, ADVANCE, DONE.
REQ-004 Sections SHALL be sent in this order:
- REG: N_REGISTER words.
- MEM: N_MEMORY_DATA words.
- PC: 1 byte, {1'b0, pc_i}.
- CYC: cycles_i, 1 word.
REQ-005 Each word SHALL be sent as 4 bytes, least-significant byte first; the total dump is 641 bytes.
REQ-006 IDLE: when start_i=1, go to FETCH with section=REG, addr_reg_o=0, addr_mem_o=0, byte index 0.
REQ-007 FETCH: hold the address for one cycle, then go to LATCH.
REQ-008 LATCH: capture the word for the current section into the internal word buffer:
- REG: data_reg_i.
- MEM: data_mem_i.
- PC: zero-extended PC.
- CYC: cycles_i.
Then go to LAUNCH.
REQ-009 LAUNCH: when tx_done_i=1, drive tx_data_o = buffer byte[index] and assert tx_start_o for exactly one cycle, then go to WAIT_BUSY; when tx_done_i=0, wait in LAUNCH with tx_start_o=0.
REQ-010 WAIT_BUSY: wait until tx_done_i=0, then go to WAIT_IDLE. No timeout.
REQ-011 WAIT_IDLE: wait until tx_done_i=1, then go to ADVANCE.
REQ-012 ADVANCE with bytes remaining in the word (index < 3; PC section has 1 byte): increment index and go to LAUNCH. The buffer is not reloaded.
REQ-013 ADVANCE at the last byte of a word: clear index, then:
- REG with addr_reg_o < N_REGISTER-1: increment addr_reg_o, go to FETCH.
- REG at N_REGISTER-1: wrap addr_reg_o to 0, go to MEM/FETCH.
- MEM with addr_mem_o < N_MEMORY_DATA-1: increment addr_mem_o, go to FETCH.
- MEM at N_MEMORY_DATA-1: wrap addr_mem_o to 0, go to PC/LATCH.
- PC: go to CYC/LATCH.
- CYC: go to DONE.
REQ-014 DONE: assert done_o for one cycle, then go to IDLE.
REQ-015 start_i SHALL be ignored in every state except IDLE, including the DONE cycle; a start_i held high through DONE begins a new dump on the following IDLE cycle.
REQ-016 At most one byte SHALL be in flight; tx_start_o is never asserted while tx_done_i=0.
REQ-017 Address counters SHALL never exceed N_REGISTER-1 or N_MEMORY_DATA-1; addresses read 0 while in IDLE.
REQ-018 tx_data_o SHALL retain the last launched byte between launches.

Reset
REQ-019 While reset_i=1 at a clock edge, the block SHALL enter IDLE and clear section, index and buffer. Outputs: tx_start_o=0, tx_data_o=0, addr_reg_o=0, addr_mem_o=0, sel_debug_o=0, busy_o=0, done_o=0.
REQ-020 Reset mid-dump SHALL abort the dump with no done_o; the next start_i restarts from REG address 0.

Verification
REQ-021 Full dump: UART model holds tx_done_i low 10 cycles per byte; register r = 0x0000_0100+r, mem m = 0xA500_0000+m, pc_i=0x2A, cycles_i=0x1234_5678, start_i pulse -> 641 tx_start_o pulses; first bytes 00 01 00 00; PC byte 2A; final bytes 78 56 34 12; done_o exactly once; busy_o low afterwards.
REQ-022 Boundaries: observe addresses -> addr_reg_o goes 31 then 0; addr_mem_o goes 126 then 0; no address 32 or 127 ever driven.
REQ-023 Handshake: hold tx_done_i=0 for 500 cycles in LAUNCH -> tx_start_o stays 0 and tx_data_o unchanged; release -> exactly one pulse.
REQ-024 start_i pulsed during the dump and high during DONE -> the running dump is unaffected; a second dump begins on the cycle after the return to IDLE.
REQ-025 reset_i asserted after byte 200 -> next cycle all outputs at reset values, no done_o; new start_i -> first byte is register 0 LSB.
REQ-026 sel_debug_o equals busy_o on every cycle of all the above scenarios.
